cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Architectural CP0 register bank for the 5-stage MIPS pipeline.
- Serves the ID-stage read port for MFC0 and ERET. Commits MTC0 writes and exception/ERET state changes at the WR (writeback) stage.
- It is the write end of the CP0 path: the CP0 forwarding unit only bypasses values that have not yet reached this block.
- Also implements the Count/Compare timer and interrupt detection, and issues the pipeline flush/redirect.

Parameters:
EXC_VECTOR, 32'h8000_0180, redirect target for syscall and interrupt entry
COUNT_DIV, 2, clock cycles per Count increment (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
rd_cs  in  5  ID read register number
rd_sel  in  3  ID read select
rd_data  out  32  combinational read data
wr_valid  in  1  an instruction is retiring in WR this cycle
wr_cp0op  in  3  WR cp0op: 000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET
wr_cs  in  5  WR register number
wr_sel  in  3  WR select
wr_data  in  32  MTC0 write data
wr_pc  in  32  PC of the WR instruction
hw_int  in  6  external interrupt lines, level-sensitive
exc_flush  out  1  flush IF..MEM and redirect this cycle
exc_pc  out  32  redirect target, valid when exc_flush=1
epc_out  out  32  current EPC
int_pending  out  1  unmasked interrupt pending

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - Status=0, Cause=0, EPC=0, Count=0, Compare=0, prescaler=0, timer_ip=0.
  - Outputs: rd_data follows the registers; exc_flush=0; exc_pc=0 while not flushing; int_pending=0.
- Implemented registers, all sel 0:
  - Count 9
  - Compare 11
  - Status 12: writable IM[15:8], EXL[1], IE[0]; other bits read 0.
  - Cause 13:
    - IP[15] = timer_ip | hw_int_q[5]
    - IP[14:10] = hw_int_q[4:0]
    - IP[9:8] software-writable
    - ExcCode[6:2]
  - EPC 14
- Any other cs, or sel!=0: reads 0, writes ignored.
- Read port:
  - Purely combinational from the registered state.
  - No internal bypass of a same-cycle WR write; the forwarding unit covers that hazard.
- hw_int is registered once into hw_int_q, giving 1-cycle latency into Cause.IP.
- MTC0 (wr_valid & op=010): register updated at the clock edge.
  - Count write also clears the prescaler.
  - Compare write clears timer_ip.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments (mod 2^32) on wrap.
  - timer_ip is set in the cycle Count becomes equal to Compare by increment.
  - A Compare write and a match in the same cycle: the write wins (timer_ip=0).
  - A Count write in the same cycle as an increment: the write wins.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
- WR events, priority highest first, evaluated combinationally. Only one takes effect per cycle.
  1. SYSCALL:
     - exc_flush=1, exc_pc=EXC_VECTOR.
     - At the edge: EPC<=wr_pc, ExcCode<=8, EXL<=1.
  2. ERET:
     - exc_flush=1, exc_pc=EPC (pre-edge value).
     - At the edge: EXL<=0.
  3. Interrupt: wr_valid & op=000 & int_pending.
     - exc_flush=1, exc_pc=EXC_VECTOR.
     - At the edge: EPC<=wr_pc+4, ExcCode<=0, EXL<=1.
     - The retiring instruction completes.
  4. MTC0: normal write, no flush.
- Interrupt deferral:
  - Interrupts are not taken when wr_cp0op!=000; they are deferred to the next eligible retirement.
  - While EXL=1, no interrupt is taken.
  - A nested SYSCALL under EXL=1 still overwrites EPC.
- wr_valid=0: all WR ops are ignored; the timer still runs.
- rst asserted mid-operation overrides every event in that cycle.
- Width: wr_pc+4 wraps mod 2^32.

Decomposition:
- cp0_pkg holds:
  - cp0op encodings (NONE, MFC0, MTC0, SYSCALL, ERET)
  - register numbers (COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14)
  - Status/Cause bit positions and masks
  - ExcCodes (INT=0, SYS=8)
- The forwarding unit uses the same package.
- One sub-module, cp0_timer: prescaler, Count, Compare, timer_ip, plus the load/clear interface.

Test Plan:
- Reset, then read cs=12,13,14,9 -> all 0. Read cs=5 or sel=1 after writing -> 0.
- MTC0 cs=14 data 32'h0040_0010 at WR -> next cycle rd_data(cs=14)=32'h0040_0010. In the write cycle rd_data still shows the old value.
- SYSCALL at WR, wr_pc=32'h0040_0020 -> same cycle exc_flush=1, exc_pc=32'h8000_0180. Next cycle EPC=32'h0040_0020, Cause[6:2]=8, Status.EXL=1. Then ERET -> exc_pc=32'h0040_0020, EXL cleared.
- COUNT_DIV=2:
  - Write Compare=5, Count=0 -> Count reaches 5 after 10 cycles; Cause[15]=1 that cycle.
  - With Status=32'h0000_8001, int_pending=1.
  - Next op=000 retirement at wr_pc=32'h100 -> flush to vector, EPC=32'h104.
- hw_int[2]=1 with Status IM[12]=1, IE=1, WR op=MTC0 -> no interrupt that cycle. Next op=000 retirement takes it.
- Simultaneous Compare write and timer match -> timer_ip stays 0. rst asserted during a SYSCALL cycle -> EPC=0, EXL=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: cp0op encodings, register numbers, Status/Cause
// field layout and exception codes. Also imported by the CP0 forwarding unit.
package cp0_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'b000,
        OP_MFC0    = 3'b001,
        OP_MTC0    = 3'b010,
        OP_SYSCALL = 3'b011,
        OP_ERET    = 3'b100
    } cp0op_e;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_IP_LSB   = 8;
    localparam int CAUSE_SW_LSB   = 8;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    // Status as seen by MFC0: IM, EXL, IE; everything else reads zero.
    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        return {16'h0000, im, 6'b00_0000, exl, ie};
    endfunction

    // Cause as seen by MFC0: IP[15:8], ExcCode[6:2]; everything else reads zero.
    function automatic logic [31:0] pack_cause(input logic [7:0] ip,
                                               input logic [4:0] exc);
        return {16'h0000, ip, 1'b0, exc, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 register bank bundle: ID read port, WR retirement port,
// external interrupt lines and the flush/redirect outputs.
interface cp0_regfile_if;
    logic [4:0]  rd_cs;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        wr_valid;
    logic [2:0]  wr_cp0op;
    logic [4:0]  wr_cs;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic [5:0]  hw_int;
    logic        exc_flush;
    logic [31:0] exc_pc;
    logic [31:0] epc_out;
    logic        int_pending;

    modport master (
        output rd_cs, rd_sel, wr_valid, wr_cp0op, wr_cs, wr_sel, wr_data, wr_pc, hw_int,
        input  rd_data, exc_flush, exc_pc, epc_out, int_pending
    );

    modport slave (
        input  rd_cs, rd_sel, wr_valid, wr_cp0op, wr_cs, wr_sel, wr_data, wr_pc, hw_int,
        output rd_data, exc_flush, exc_pc, epc_out, int_pending
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler divides the clock by COUNT_DIV, Count
// increments on each prescaler wrap, timer_ip latches when an increment makes
// Count equal Compare. Software loads of Count/Compare take priority.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_ip
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_timer_ip;
    logic          w_wrap;
    logic [31:0]   w_count_inc;

    assign w_wrap      = (r_presc == PRESC_MAX);
    assign w_count_inc = r_count + 32'd1;

    // Prescaler, Count, Compare and timer interrupt state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc    <= {PW{1'b0}};
            r_count    <= 32'h0000_0000;
            r_compare  <= 32'h0000_0000;
            r_timer_ip <= 1'b0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
                r_presc <= {PW{1'b0}};
            end else if (w_wrap) begin
                r_count <= w_count_inc;
                r_presc <= {PW{1'b0}};
            end else begin
                r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
            end

            if (i_compare_we) begin
                r_compare <= i_wdata;
            end else begin
                r_compare <= r_compare;
            end

            // A Compare write acknowledges the interrupt even if a match lands
            // in the same cycle; a Count load suppresses the increment match.
            if (i_compare_we) begin
                r_timer_ip <= 1'b0;
            end else if (!i_count_we && w_wrap && (w_count_inc == r_compare)) begin
                r_timer_ip <= 1'b1;
            end else begin
                r_timer_ip <= r_timer_ip;
            end
        end
    end

    assign o_count    = r_count;
    assign o_compare  = r_compare;
    assign o_timer_ip = r_timer_ip;

endmodule

// File: rtl/cp0_regfile.sv
// Architectural CP0 register bank. Combinational ID read port, WR-stage
// commit of MTC0 / SYSCALL / ERET / interrupt entry, and flush/redirect.
// No read bypass of a same-cycle write: the forwarding unit covers that.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          COUNT_DIV  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cp0_regfile_if.slave  bus
);

    logic [5:0]  r_hw_int_q;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    cp0op_e      w_op;
    logic        w_wr_sel0;
    logic [7:0]  w_ip;
    logic        w_int_pending;
    logic        w_sys;
    logic        w_eret;
    logic        w_int;
    logic        w_mtc0;
    logic        w_flush;
    logic [31:0] w_exc_pc;
    logic        w_count_we;
    logic        w_compare_we;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_ip;
    logic [31:0] w_rd_data;

    assign w_op      = cp0op_e'(bus.wr_cp0op);
    assign w_wr_sel0 = (bus.wr_sel == 3'd0);

    assign w_ip = {w_timer_ip | r_hw_int_q[5], r_hw_int_q[4:0], r_ip_sw};
    assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));

    // Decode the single WR event for this cycle; reset suppresses all of them.
    always_comb begin
        w_sys  = 1'b0;
        w_eret = 1'b0;
        w_int  = 1'b0;
        w_mtc0 = 1'b0;
        if (!i_rst && bus.wr_valid) begin
            case (w_op)
                OP_SYSCALL: w_sys  = 1'b1;
                OP_ERET:    w_eret = 1'b1;
                OP_NONE:    w_int  = w_int_pending;
                OP_MTC0:    w_mtc0 = 1'b1;
                default:    w_mtc0 = 1'b0;
            endcase
        end else begin
            w_mtc0 = 1'b0;
        end
    end

    // Redirect target: vector for SYSCALL/interrupt, pre-edge EPC for ERET.
    always_comb begin
        w_flush = w_sys | w_eret | w_int;
        if (w_sys || w_int) begin
            w_exc_pc = EXC_VECTOR;
        end else if (w_eret) begin
            w_exc_pc = r_epc;
        end else begin
            w_exc_pc = 32'h0000_0000;
        end
    end

    assign w_count_we   = w_mtc0 & w_wr_sel0 & (bus.wr_cs == REG_COUNT);
    assign w_compare_we = w_mtc0 & w_wr_sel0 & (bus.wr_cs == REG_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (bus.wr_data),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_ip   (w_timer_ip)
    );

    // Status/Cause/EPC commit and interrupt line synchroniser stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hw_int_q <= 6'b00_0000;
            r_im       <= 8'h00;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_ip_sw    <= 2'b00;
            r_exccode  <= 5'd0;
            r_epc      <= 32'h0000_0000;
        end else begin
            r_hw_int_q <= bus.hw_int;
            if (w_sys) begin
                r_epc     <= bus.wr_pc;
                r_exccode <= EXC_SYS;
                r_exl     <= 1'b1;
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end else if (w_int) begin
                r_epc     <= bus.wr_pc + 32'd4;
                r_exccode <= EXC_INT;
                r_exl     <= 1'b1;
            end else if (w_mtc0 && w_wr_sel0) begin
                case (bus.wr_cs)
                    REG_STATUS: begin
                        r_im  <= bus.wr_data[STATUS_IM_LSB +: 8];
                        r_exl <= bus.wr_data[STATUS_EXL_BIT];
                        r_ie  <= bus.wr_data[STATUS_IE_BIT];
                    end
                    REG_CAUSE: r_ip_sw <= bus.wr_data[CAUSE_SW_LSB +: 2];
                    REG_EPC:   r_epc   <= bus.wr_data;
                    default:   r_epc   <= r_epc;
                endcase
            end else begin
                r_epc <= r_epc;
            end
        end
    end

    // ID read mux; unimplemented registers and nonzero selects read zero.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (bus.rd_sel == 3'd0) begin
            case (bus.rd_cs)
                REG_COUNT:   w_rd_data = w_count;
                REG_COMPARE: w_rd_data = w_compare;
                REG_STATUS:  w_rd_data = pack_status(r_im, r_exl, r_ie);
                REG_CAUSE:   w_rd_data = pack_cause(w_ip, r_exccode);
                REG_EPC:     w_rd_data = r_epc;
                default:     w_rd_data = 32'h0000_0000;
            endcase
        end else begin
            w_rd_data = 32'h0000_0000;
        end
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.exc_flush   = w_flush;
    assign bus.exc_pc      = w_exc_pc;
    assign bus.epc_out     = r_epc;
    assign bus.int_pending = w_int_pending;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios followed by a
// randomized phase checked against a word-level model of the CP0 registers.
module tb_cp0_regfile;

    localparam logic [31:0] VEC = 32'h8000_0180;
    localparam int          DIV = 2;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_MFC0 = 3'd1;
    localparam logic [2:0] T_MTC0 = 3'd2;
    localparam logic [2:0] T_SYS  = 3'd3;
    localparam logic [2:0] T_ERET = 3'd4;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    cp0_regfile_if bus();

    cp0_regfile #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0; bus.wr_cp0op = 3'd0; bus.wr_cs = 5'd0;
        bus.wr_sel = 3'd0; bus.wr_data = 32'h0; bus.wr_pc = 32'h0;
    endtask

    task automatic wr(input logic [2:0] op, input logic [4:0] cs, input logic [2:0] sel,
                      input logic [31:0] d, input logic [31:0] pc);
        bus.wr_valid = 1'b1; bus.wr_cp0op = op; bus.wr_cs = cs;
        bus.wr_sel = sel; bus.wr_data = d; bus.wr_pc = pc;
    endtask

    task automatic rdchk(input string tag, input logic [4:0] cs, input logic [2:0] sel,
                         input logic [31:0] exp);
        bus.rd_cs = cs; bus.rd_sel = sel;
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    // model state for the randomized phase
    logic [31:0] m_status, m_epc, m_compare, cnt_base, exp_rd, exp_pc, cnt, cause, d, pc;
    logic [4:0]  m_exc, cs;
    logic [1:0]  m_sw;
    logic [5:0]  m_prev_hw, hw;
    logic [7:0]  ip;
    logic [2:0]  op, sel, rsel;
    logic [4:0]  rcs;
    logic        valid, pend, ev_sys, ev_eret, ev_int, ev_mt;
    int          cnt_edge, k;
    logic [4:0]  wcs_tab [8];
    logic [4:0]  rcs_tab [8];

    initial begin
        wcs_tab = '{5'd0, 5'd5, 5'd9, 5'd12, 5'd12, 5'd13, 5'd14, 5'd14};
        rcs_tab = '{5'd0, 5'd5, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd31};

        // ---- reset ----
        rst = 1'b1; idle(); bus.hw_int = 6'd0; bus.rd_cs = 5'd0; bus.rd_sel = 3'd0;
        cyc(); cyc();
        rst = 1'b0;
        rdchk("rst_status", 5'd12, 3'd0, 32'h0);
        rdchk("rst_cause",  5'd13, 3'd0, 32'h0);
        rdchk("rst_epc",    5'd14, 3'd0, 32'h0);
        rdchk("rst_count",  5'd9,  3'd0, 32'h0);
        rdchk("rst_compare",5'd11, 3'd0, 32'h0);
        check("rst_flush", {31'd0, bus.exc_flush}, 32'd0);
        check("rst_exc_pc", bus.exc_pc, 32'h0);
        check("rst_int_pending", {31'd0, bus.int_pending}, 32'd0);

        // ---- MTC0 EPC, no same-cycle bypass ----
        wr(T_MTC0, 5'd14, 3'd0, 32'h0040_0010, 32'h0);
        rdchk("mtc0_epc_old", 5'd14, 3'd0, 32'h0);
        check("mtc0_no_flush", {31'd0, bus.exc_flush}, 32'd0);
        cyc(); idle();
        rdchk("mtc0_epc_new", 5'd14, 3'd0, 32'h0040_0010);
        check("epc_out", bus.epc_out, 32'h0040_0010);

        // ---- unimplemented register / nonzero select ----
        wr(T_MTC0, 5'd5, 3'd0, 32'hFFFF_FFFF, 32'h0); cyc();
        wr(T_MTC0, 5'd14, 3'd1, 32'hDEAD_BEEF, 32'h0); cyc(); idle();
        rdchk("rd_cs5", 5'd5, 3'd0, 32'h0);
        rdchk("rd_sel1", 5'd14, 3'd1, 32'h0);
        rdchk("sel1_write_ignored", 5'd14, 3'd0, 32'h0040_0010);

        // ---- SYSCALL then ERET ----
        wr(T_SYS, 5'd0, 3'd0, 32'h0, 32'h0040_0020); #1;
        check("sys_flush", {31'd0, bus.exc_flush}, 32'd1);
        check("sys_exc_pc", bus.exc_pc, VEC);
        cyc(); idle();
        rdchk("sys_epc", 5'd14, 3'd0, 32'h0040_0020);
        rdchk("sys_cause", 5'd13, 3'd0, 32'h0000_0020);
        rdchk("sys_status", 5'd12, 3'd0, 32'h0000_0002);
        wr(T_ERET, 5'd0, 3'd0, 32'h0, 32'h0); #1;
        check("eret_flush", {31'd0, bus.exc_flush}, 32'd1);
        check("eret_exc_pc", bus.exc_pc, 32'h0040_0020);
        cyc(); idle();
        rdchk("eret_status", 5'd12, 3'd0, 32'h0);
        check("idle_no_flush", {31'd0, bus.exc_flush}, 32'd0);

        // ---- timer match at Compare=5 ----
        wr(T_MTC0, 5'd11, 3'd0, 32'd5, 32'h0); cyc();
        wr(T_MTC0, 5'd9, 3'd0, 32'd0, 32'h0); cyc(); idle();
        k = edges;
        for (int i = 0; i <= 10; i++) begin
            cnt = 32'((edges - k) / DIV);
            rdchk("timer_count", 5'd9, 3'd0, cnt);
            rdchk("timer_cause", 5'd13, 3'd0, 32'h20 | ((cnt == 32'd5) ? 32'h8000 : 32'h0));
            if (i < 10) cyc();
        end
        wr(T_MTC0, 5'd12, 3'd0, 32'h0000_8001, 32'h0); cyc(); idle(); #1;
        check("timer_int_pending", {31'd0, bus.int_pending}, 32'd1);
        wr(T_NONE, 5'd0, 3'd0, 32'h0, 32'h0000_0100); #1;
        check("tint_flush", {31'd0, bus.exc_flush}, 32'd1);
        check("tint_exc_pc", bus.exc_pc, VEC);
        cyc(); idle();
        rdchk("tint_epc", 5'd14, 3'd0, 32'h0000_0104);
        rdchk("tint_cause", 5'd13, 3'd0, 32'h0000_8000);
        rdchk("tint_status", 5'd12, 3'd0, 32'h0000_8003);
        check("exl_masks_pending", {31'd0, bus.int_pending}, 32'd0);
        wr(T_NONE, 5'd0, 3'd0, 32'h0, 32'h0000_0500); #1;
        check("exl_no_int", {31'd0, bus.exc_flush}, 32'd0);
        cyc(); idle();

        // ---- hw_int deferred behind MTC0 ----
        wr(T_MTC0, 5'd11, 3'd0, 32'hFFFF_0000, 32'h0); cyc();
        wr(T_MTC0, 5'd12, 3'd0, 32'h0000_1001, 32'h0); cyc(); idle();
        bus.hw_int = 6'b00_0100; #1;
        check("hw_latency_pending", {31'd0, bus.int_pending}, 32'd0);
        rdchk("hw_latency_cause", 5'd13, 3'd0, 32'h0);
        cyc();
        rdchk("hw_cause", 5'd13, 3'd0, 32'h0000_1000);
        check("hw_pending", {31'd0, bus.int_pending}, 32'd1);
        wr(T_MTC0, 5'd5, 3'd0, 32'h0, 32'h0000_01F0); #1;
        check("int_deferred_mtc0", {31'd0, bus.exc_flush}, 32'd0);
        cyc();
        wr(T_NONE, 5'd0, 3'd0, 32'h0, 32'h0000_0200); #1;
        check("hw_int_flush", {31'd0, bus.exc_flush}, 32'd1);
        check("hw_int_exc_pc", bus.exc_pc, VEC);
        cyc(); idle(); bus.hw_int = 6'd0;
        rdchk("hw_int_epc", 5'd14, 3'd0, 32'h0000_0204);
        rdchk("hw_int_status", 5'd12, 3'd0, 32'h0000_1003);

        // ---- Compare write collides with match ----
        wr(T_MTC0, 5'd12, 3'd0, 32'h0, 32'h0); cyc();
        wr(T_MTC0, 5'd11, 3'd0, 32'd3, 32'h0); cyc();
        wr(T_MTC0, 5'd9, 3'd0, 32'd0, 32'h0); cyc(); idle();
        repeat (5) cyc();
        wr(T_MTC0, 5'd11, 3'd0, 32'd3, 32'h0); cyc(); idle();
        rdchk("collide_count", 5'd9, 3'd0, 32'd3);
        rdchk("collide_cause", 5'd13, 3'd0, 32'h0);

        // ---- reset during SYSCALL ----
        wr(T_SYS, 5'd0, 3'd0, 32'h0, 32'h0000_0300); rst = 1'b1; #1;
        check("rst_sys_flush", {31'd0, bus.exc_flush}, 32'd0);
        cyc(); rst = 1'b0; idle();
        rdchk("rst_sys_epc", 5'd14, 3'd0, 32'h0);
        rdchk("rst_sys_status", 5'd12, 3'd0, 32'h0);
        rdchk("rst_sys_count", 5'd9, 3'd0, 32'h0);

        // ---- randomized phase against the model ----
        m_status = 32'h0; m_epc = 32'h0; m_exc = 5'd0; m_sw = 2'd0; m_prev_hw = 6'd0;
        cnt_base = 32'h0; cnt_edge = edges;
        wr(T_MTC0, 5'd11, 3'd0, 32'hFFFF_0000, 32'h0); cyc(); idle();
        m_compare = 32'hFFFF_0000;

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                4, 5:    op = T_MTC0;
                6:       op = T_MFC0;
                7:       op = T_SYS;
                8:       op = T_ERET;
                default: op = T_NONE;
            endcase
            valid = ($urandom_range(0, 7) != 0);
            cs    = wcs_tab[$urandom_range(0, 7)];
            sel   = ($urandom_range(0, 5) == 0) ? 3'd1 : 3'd0;
            d     = (cs == 5'd9) ? 32'($urandom_range(0, 1000)) : $urandom;
            pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            hw    = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            rcs   = rcs_tab[$urandom_range(0, 7)];
            rsel  = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0;

            bus.wr_valid = valid; bus.wr_cp0op = op; bus.wr_cs = cs; bus.wr_sel = sel;
            bus.wr_data = d; bus.wr_pc = pc; bus.hw_int = hw;
            bus.rd_cs = rcs; bus.rd_sel = rsel;
            #1;

            cnt   = cnt_base + 32'((edges - cnt_edge) / DIV);
            ip    = {m_prev_hw, m_sw};
            pend  = m_status[0] & ~m_status[1] & (|(ip & m_status[15:8]));
            cause = ({24'd0, ip} << 8) | ({27'd0, m_exc} << 2);
            if (rsel != 3'd0)         exp_rd = 32'h0;
            else if (rcs == 5'd9)     exp_rd = cnt;
            else if (rcs == 5'd11)    exp_rd = m_compare;
            else if (rcs == 5'd12)    exp_rd = m_status;
            else if (rcs == 5'd13)    exp_rd = cause;
            else if (rcs == 5'd14)    exp_rd = m_epc;
            else                      exp_rd = 32'h0;
            ev_sys  = valid && (op == T_SYS);
            ev_eret = valid && (op == T_ERET);
            ev_int  = valid && (op == T_NONE) && pend;
            ev_mt   = valid && (op == T_MTC0);
            exp_pc  = (ev_sys || ev_int) ? VEC : (ev_eret ? m_epc : 32'h0);

            check("rnd_rd_data", bus.rd_data, exp_rd);
            check("rnd_flush", {31'd0, bus.exc_flush}, {31'd0, ev_sys | ev_eret | ev_int});
            check("rnd_exc_pc", bus.exc_pc, exp_pc);
            check("rnd_int_pending", {31'd0, bus.int_pending}, {31'd0, pend});
            check("rnd_epc_out", bus.epc_out, m_epc);

            cyc();

            if (ev_sys) begin
                m_epc = pc; m_exc = 5'd8; m_status = m_status | 32'h2;
            end else if (ev_eret) begin
                m_status = m_status & ~32'h2;
            end else if (ev_int) begin
                m_epc = pc + 32'd4; m_exc = 5'd0; m_status = m_status | 32'h2;
            end else if (ev_mt && sel == 3'd0) begin
                if (cs == 5'd12)      m_status = d & 32'h0000_FF03;
                else if (cs == 5'd13) m_sw = d[9:8];
                else if (cs == 5'd14) m_epc = d;
                else if (cs == 5'd9) begin cnt_base = d; cnt_edge = edges; end
            end
            m_prev_hw = hw;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
